// File: rtl/arbitro_rr_if.sv
// Request/grant bundle between the requesting units (master) and the round-robin arbiter (slave).
interface arbitro_rr_if;
  logic [3:0] R;
  logic       Done;
  logic [3:0] Grant;
  logic [1:0] Grant_num;
  logic       Av;
  logic       Timeout;

  modport master (output R, Done, input Grant, Grant_num, Av, Timeout);
  modport slave  (input R, Done, output Grant, Grant_num, Av, Timeout);
endinterface

// File: rtl/arbitro_rr.sv
// Four-way round-robin arbiter with ownership hold, explicit release, hold timeout
// and a one-cycle turnaround gap after each release.
//
// state  | meaning
// IDLE   | resource free, arbitrating R from the rotating pointer
// BUSY   | Grant_num owns the resource, hold counter running
// GAP    | one-cycle bus turnaround after a release
module arbitro_rr #(
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  arbitro_rr_if.slave  bus
);

  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state_q;
  logic [1:0]        ptr_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [3:0]        grant_q;
  logic [1:0]        grant_num_q;
  logic              av_q;
  logic              timeout_q;

  logic [1:0]        win_d;
  logic              at_limit;
  logic              owner_req;
  logic              release_d;

  // Lowest offset from ptr wins; the loop runs downward so the nearest set bit is assigned last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign win_d     = rr_pick(bus.R, ptr_q);
  assign at_limit  = (hold_cnt_q == HOLD_LAST);
  assign owner_req = bus.R[grant_num_q];
  assign release_d = bus.Done | ~owner_req | at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 2'd0;
      hold_cnt_q  <= '0;
      grant_q     <= 4'b0000;
      grant_num_q <= 2'd0;
      av_q        <= 1'b1;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|bus.R) begin
            grant_q     <= 4'b0001 << win_d;
            grant_num_q <= win_d;
            av_q        <= 1'b0;
            hold_cnt_q  <= '0;
            state_q     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (release_d) begin
            grant_q     <= 4'b0000;
            grant_num_q <= 2'd0;
            av_q        <= 1'b1;
            ptr_q       <= grant_num_q + 2'd1;
            hold_cnt_q  <= '0;
            // Forced release only when the limit is the sole cause.
            timeout_q   <= at_limit & ~bus.Done & owner_req;
            state_q     <= S_GAP;
          end else begin
            hold_cnt_q  <= hold_cnt_q + HOLD_W'(1);
          end
        end
        S_GAP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Grant     = grant_q;
  assign bus.Grant_num = grant_num_q;
  assign bus.Av        = av_q;
  assign bus.Timeout   = timeout_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed self-checking bench for arbitro_rr (MAX_HOLD=4).
module tb_arbitro_rr;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  arbitro_rr_if bus ();

  arbitro_rr #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] n,
                     input logic av, input logic to);
    logic [7:0] got;
    logic [7:0] exp;
    got = {bus.Grant, bus.Grant_num, bus.Av, bus.Timeout};
    exp = {g, n, av, to};
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s got G/n/Av/To=%b/%0d/%b/%b exp=%b/%0d/%b/%b", tag,
               got[7:4], got[3:2], got[1], got[0], g, n, av, to);
      end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.R    = 4'b0000;
    bus.Done = 1'b0;
    tick();
    tick();
    chk("reset_state", 4'b0000, 2'd0, 1'b1, 1'b0);

    // Reset mid-grant
    rst   = 1'b0;
    bus.R = 4'b1111;
    tick();
    chk("first_grant_0", 4'b0001, 2'd0, 1'b0, 1'b0);
    tick();
    #3 rst = 1'b1;
    #1 chk("async_reset_mid_grant", 4'b0000, 2'd0, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    chk("grant_0_after_reset_ptr_kept", 4'b0001, 2'd0, 1'b0, 1'b0);
    bus.R = 4'b0000;
    tick();
    chk("drop_release_owner0", 4'b0000, 2'd0, 1'b1, 1'b0);
    tick();
    chk("idle_no_req", 4'b0000, 2'd0, 1'b1, 1'b0);

    // Single requester 2, ptr=1
    bus.R = 4'b0100;
    tick();
    chk("single_grant_edge1", 4'b0100, 2'd2, 1'b0, 1'b0);
    tick();
    tick();
    chk("single_hold_edge3", 4'b0100, 2'd2, 1'b0, 1'b0);
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    chk("single_done_gap_edge4", 4'b0000, 2'd0, 1'b1, 1'b0);
    tick();
    chk("single_idle_edge5", 4'b0000, 2'd0, 1'b1, 1'b0);
    tick();
    chk("single_regrant_edge6", 4'b0100, 2'd2, 1'b0, 1'b0);
    bus.R = 4'b0000;
    tick();
    tick();

    // Request drop by owner 3, ptr wraps to 0; spurious Done in GAP and IDLE
    bus.R = 4'b1000;
    tick();
    chk("grant_3", 4'b1000, 2'd3, 1'b0, 1'b0);
    bus.R = 4'b0000;
    tick();
    chk("drop_release_owner3", 4'b0000, 2'd0, 1'b1, 1'b0);
    bus.Done = 1'b1;
    tick();
    chk("done_in_gap_ignored", 4'b0000, 2'd0, 1'b1, 1'b0);
    tick();
    chk("done_in_idle_ignored", 4'b0000, 2'd0, 1'b1, 1'b0);
    bus.Done = 1'b0;

    // Rotation 0,1,2,3,0 with R=1111
    bus.R = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rot_grant_%0d", k), 4'b0001 << (k % 4), 2'(k % 4), 1'b0, 1'b0);
      bus.Done = 1'b1;
      tick();
      bus.Done = 1'b0;
      chk($sformatf("rot_gap_%0d", k), 4'b0000, 2'd0, 1'b1, 1'b0);
      tick();
      chk($sformatf("rot_idle_%0d", k), 4'b0000, 2'd0, 1'b1, 1'b0);
    end
    bus.R = 4'b0000;
    tick();

    // Pointer skip: owner 1 releases -> ptr=2, R=0011 -> winner 0
    bus.R = 4'b0010;
    tick();
    chk("skip_grant_1", 4'b0010, 2'd1, 1'b0, 1'b0);
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    bus.R = 4'b0011;
    tick();
    tick();
    chk("skip_winner_0", 4'b0001, 2'd0, 1'b0, 1'b0);
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    bus.R = 4'b0000;
    tick();

    // Timeout: ptr=1, R=0010 held, no Done -> 4 BUSY cycles then Timeout pulse
    bus.R = 4'b0010;
    tick();
    chk("to_busy_1", 4'b0010, 2'd1, 1'b0, 1'b0);
    tick();
    chk("to_busy_2", 4'b0010, 2'd1, 1'b0, 1'b0);
    tick();
    chk("to_busy_3", 4'b0010, 2'd1, 1'b0, 1'b0);
    tick();
    chk("to_busy_4", 4'b0010, 2'd1, 1'b0, 1'b0);
    tick();
    chk("to_forced_release", 4'b0000, 2'd0, 1'b1, 1'b1);
    bus.R = 4'b0011;
    tick();
    chk("to_pulse_one_cycle", 4'b0000, 2'd0, 1'b1, 1'b0);

    // ptr=2 after timeout: R=0011 -> winner 0; Done on 4th BUSY cycle -> no Timeout
    tick();
    chk("to2_ptr2_winner0", 4'b0001, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("to2_busy_4", 4'b0001, 2'd0, 1'b0, 1'b0);
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    chk("to2_done_at_limit_no_timeout", 4'b0000, 2'd0, 1'b1, 1'b0);
    bus.R = 4'b0000;
    tick();
    chk("to2_idle", 4'b0000, 2'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
